hazard_control_unit: RTL and testbench

- Central pipeline controller for the 5-stage MIPS core.
- Detects load-use hazards, taken branches/jumps and data-memory wait, and drives the 2-bit control codes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable.
- Holds its own FSM for multi-cycle stalls and memory wait.
- Keeps saturating performance counters.

---
 rtl/hazard_control_unit_if.sv | 51 +++++
 rtl/hazard_control_unit.sv | 170 +++++++++++++++++
 tb/tb_hazard_control_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// ============================================================================
//  Module      : hazard_control_unit_if
//  Description : Signal bundle between the pipeline datapath and the hazard
//                control unit. The datapath (master) reports hazard sources
//                and memory status. The control unit (slave) returns the
//                pipeline-register control codes, the PC enable and the
//                status counters.
//  Signals     : ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
//                JumpID, BranchTaken, MemBusy        (datapath -> unit)
//                PCWrite, IF_ID_Signal, ID_EX_Signal, EX_MEM_Signal,
//                MEM_WB_Signal, MemTimeout, StallCycles,
//                FlushEvents                         (unit -> datapath)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_control_unit_if;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_Rt;
    logic [4:0]  IF_ID_Rs;
    logic [4:0]  IF_ID_Rt;
    logic        IF_ID_UsesRt;
    logic        JumpID;
    logic        BranchTaken;
    logic        MemBusy;

    logic        PCWrite;
    logic [1:0]  IF_ID_Signal;
    logic [1:0]  ID_EX_Signal;
    logic [1:0]  EX_MEM_Signal;
    logic [1:0]  MEM_WB_Signal;
    logic        MemTimeout;
    logic [31:0] StallCycles;
    logic [31:0] FlushEvents;

    modport master (
        output ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
               JumpID, BranchTaken, MemBusy,
        input  PCWrite, IF_ID_Signal, ID_EX_Signal, EX_MEM_Signal,
               MEM_WB_Signal, MemTimeout, StallCycles, FlushEvents
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
               JumpID, BranchTaken, MemBusy,
        output PCWrite, IF_ID_Signal, ID_EX_Signal, EX_MEM_Signal,
               MEM_WB_Signal, MemTimeout, StallCycles, FlushEvents
    );
endinterface

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
//  Module      : hazard_control_unit
//  Description : Central pipeline controller for the 5-stage MIPS core.
//                Detects load-use hazards, taken branches/jumps and
//                data-memory wait. Drives the IF/ID, ID/EX, EX/MEM and MEM/WB
//                control codes (0 advance, 1 hold, 2 flush) and the PC write
//                enable. Keeps saturating stall/flush counters and a sticky
//                memory-timeout flag.
//  Ports       : Clock  - core clock, all state updates on posedge
//                Reset  - asynchronous active-high, clears all state
//                bus    - hazard_control_unit_if.slave (see interface file)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_control_unit #(
    parameter int LOAD_STALL_CYCLES = 1,   // 1..7
    parameter int MEM_TIMEOUT       = 64   // 2..255
) (
    input  wire logic              Clock,
    input  wire logic              Reset,
    hazard_control_unit_if.slave   bus
);

    localparam logic [1:0] c_ADVANCE = 2'd0;
    localparam logic [1:0] c_HOLD    = 2'd1;
    localparam logic [1:0] c_FLUSH   = 2'd2;

    localparam logic [2:0] c_LOAD_STALL_CYCLES = 3'(LOAD_STALL_CYCLES);
    localparam logic [7:0] c_MEM_TIMEOUT       = 8'(MEM_TIMEOUT);
    localparam logic [31:0] c_CNT_MAX          = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MEM_WAIT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      r_ret_state;
    logic [2:0]  r_stall_cnt;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_timeout;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    state_t      w_next_state;
    state_t      w_next_ret_state;
    state_t      w_eff_state;
    logic [2:0]  w_next_stall_cnt;
    logic [7:0]  w_next_wait_cnt;
    logic        w_timeout_hit;
    logic        w_lu;
    logic        w_pc_write;
    logic        w_flush_event;
    logic [1:0]  w_if_id;
    logic [1:0]  w_id_ex;
    logic [1:0]  w_ex_mem;
    logic [1:0]  w_mem_wb;

    // Load-use hazard: a load in EX writes a register the instruction in ID
    // reads. $0 is never a real dependency.
    assign w_lu = bus.ID_EX_MemRead && (bus.ID_EX_Rt != 5'd0) &&
                  ((bus.ID_EX_Rt == bus.IF_ID_Rs) ||
                   (bus.IF_ID_UsesRt && (bus.ID_EX_Rt == bus.IF_ID_Rt)));

    // On the cycle memory becomes ready the saved state is resumed and the
    // same cycle is evaluated as if that state were current.
    assign w_eff_state = (r_state == S_MEM_WAIT) ? r_ret_state : r_state;

    // Wait counter saturates at the timeout value. The flag is visible in the
    // busy cycle whose count reaches the limit.
    always_comb begin
        w_next_wait_cnt = 8'd0;
        if (bus.MemBusy) begin
            w_next_wait_cnt = (r_wait_cnt == c_MEM_TIMEOUT) ? r_wait_cnt
                                                            : r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout_hit = bus.MemBusy && (w_next_wait_cnt == c_MEM_TIMEOUT);

    // Next-state and control-code decode, priority:
    // MemBusy > BranchTaken > load stall (LOAD_STALL or LU) > JumpID.
    always_comb begin
        w_next_state     = w_eff_state;
        w_next_ret_state = r_ret_state;
        w_next_stall_cnt = r_stall_cnt;
        w_pc_write       = 1'b1;
        w_flush_event    = 1'b0;
        w_if_id          = c_ADVANCE;
        w_id_ex          = c_ADVANCE;
        w_ex_mem         = c_ADVANCE;
        w_mem_wb         = c_ADVANCE;

        if (bus.MemBusy) begin
            w_pc_write       = 1'b0;
            w_if_id          = c_HOLD;
            w_id_ex          = c_HOLD;
            w_ex_mem         = c_HOLD;
            w_mem_wb         = c_FLUSH;
            w_next_state     = S_MEM_WAIT;
            w_next_ret_state = w_eff_state;
        end else if (bus.BranchTaken) begin
            w_if_id       = c_FLUSH;
            w_id_ex       = c_FLUSH;
            w_ex_mem      = c_FLUSH;
            w_flush_event = 1'b1;
            w_next_state  = S_RUN;
        end else if (w_eff_state == S_LOAD_STALL) begin
            w_pc_write       = 1'b0;
            w_if_id          = c_HOLD;
            w_id_ex          = c_FLUSH;
            w_next_stall_cnt = r_stall_cnt - 3'd1;
            if (r_stall_cnt == 3'd1) begin
                w_next_state = S_RUN;
            end
        end else if (w_lu) begin
            // A jump coincident with the hazard is dropped here; it stays in
            // ID and is decoded again once the stall ends.
            w_pc_write = 1'b0;
            w_if_id    = c_HOLD;
            w_id_ex    = c_FLUSH;
            if (LOAD_STALL_CYCLES > 1) begin
                w_next_stall_cnt = c_LOAD_STALL_CYCLES - 3'd1;
                w_next_state     = S_LOAD_STALL;
            end
        end else if (bus.JumpID) begin
            w_if_id       = c_FLUSH;
            w_flush_event = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state        <= S_RUN;
            r_ret_state    <= S_RUN;
            r_stall_cnt    <= 3'd0;
            r_wait_cnt     <= 8'd0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            r_state       <= w_next_state;
            r_ret_state   <= w_next_ret_state;
            r_stall_cnt   <= w_next_stall_cnt;
            r_wait_cnt    <= w_next_wait_cnt;
            r_mem_timeout <= r_mem_timeout | w_timeout_hit;
            if (!w_pc_write && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush_event && (r_flush_events != c_CNT_MAX)) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    // While reset is held every stage is flushed and the PC is frozen.
    assign bus.PCWrite       = Reset ? 1'b0    : w_pc_write;
    assign bus.IF_ID_Signal  = Reset ? c_FLUSH : w_if_id;
    assign bus.ID_EX_Signal  = Reset ? c_FLUSH : w_id_ex;
    assign bus.EX_MEM_Signal = Reset ? c_FLUSH : w_ex_mem;
    assign bus.MEM_WB_Signal = Reset ? c_FLUSH : w_mem_wb;
    assign bus.MemTimeout    = !Reset && (r_mem_timeout || w_timeout_hit);
    assign bus.StallCycles   = r_stall_cycles;
    assign bus.FlushEvents   = r_flush_events;

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
//  Module      : tb_hazard_control_unit
//  Description : Self-checking bench for hazard_control_unit. Three instances
//                share one stimulus stream: default parameters, a 3-cycle
//                load stall, and a 4-cycle memory timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

    logic Clock;
    logic Reset;

    hazard_control_unit_if ha ();
    hazard_control_unit_if hb ();
    hazard_control_unit_if hc ();

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(64)) dut_a (
        .Clock(Clock), .Reset(Reset), .bus(ha));
    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(64)) dut_b (
        .Clock(Clock), .Reset(Reset), .bus(hb));
    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4)) dut_c (
        .Clock(Clock), .Reset(Reset), .bus(hc));

    assign hb.ID_EX_MemRead = ha.ID_EX_MemRead;
    assign hb.ID_EX_Rt      = ha.ID_EX_Rt;
    assign hb.IF_ID_Rs      = ha.IF_ID_Rs;
    assign hb.IF_ID_Rt      = ha.IF_ID_Rt;
    assign hb.IF_ID_UsesRt  = ha.IF_ID_UsesRt;
    assign hb.JumpID        = ha.JumpID;
    assign hb.BranchTaken   = ha.BranchTaken;
    assign hb.MemBusy       = ha.MemBusy;
    assign hc.ID_EX_MemRead = ha.ID_EX_MemRead;
    assign hc.ID_EX_Rt      = ha.ID_EX_Rt;
    assign hc.IF_ID_Rs      = ha.IF_ID_Rs;
    assign hc.IF_ID_Rt      = ha.IF_ID_Rt;
    assign hc.IF_ID_UsesRt  = ha.IF_ID_UsesRt;
    assign hc.JumpID        = ha.JumpID;
    assign hc.BranchTaken   = ha.BranchTaken;
    assign hc.MemBusy       = ha.MemBusy;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Codes packed as {IF_ID, ID_EX, EX_MEM, MEM_WB}.
    localparam logic [7:0] c_RUN   = 8'h00;
    localparam logic [7:0] c_STALL = 8'h60;
    localparam logic [7:0] c_HOLDC = 8'h56;
    localparam logic [7:0] c_BRCH  = 8'hA8;
    localparam logic [7:0] c_JUMP  = 8'h80;
    localparam logic [7:0] c_RST   = 8'hAA;

    typedef struct {
        logic       mr;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       j;
        logic       b;
        logic       mb;
        logic       epc;
        logic [7:0] ecodes;
    } vec_t;

    typedef struct {
        int         sel;
        logic       pc;
        logic [7:0] codes;
        string      nm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[14];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic get_out(input int sel, output logic pc, output logic [7:0] codes,
                           output logic [31:0] stc, output logic [31:0] fle,
                           output logic to);
        case (sel)
            0: begin
                pc = ha.PCWrite; stc = ha.StallCycles; fle = ha.FlushEvents; to = ha.MemTimeout;
                codes = {ha.IF_ID_Signal, ha.ID_EX_Signal, ha.EX_MEM_Signal, ha.MEM_WB_Signal};
            end
            1: begin
                pc = hb.PCWrite; stc = hb.StallCycles; fle = hb.FlushEvents; to = hb.MemTimeout;
                codes = {hb.IF_ID_Signal, hb.ID_EX_Signal, hb.EX_MEM_Signal, hb.MEM_WB_Signal};
            end
            default: begin
                pc = hc.PCWrite; stc = hc.StallCycles; fle = hc.FlushEvents; to = hc.MemTimeout;
                codes = {hc.IF_ID_Signal, hc.ID_EX_Signal, hc.EX_MEM_Signal, hc.MEM_WB_Signal};
            end
        endcase
    endtask

    task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                          input logic [4:0] rt, input logic ur, input logic j,
                          input logic b, input logic mb);
        ha.ID_EX_MemRead = mr; ha.ID_EX_Rt = ert; ha.IF_ID_Rs = rs; ha.IF_ID_Rt = rt;
        ha.IF_ID_UsesRt = ur; ha.JumpID = j; ha.BranchTaken = b; ha.MemBusy = mb;
    endtask

    // Drive one cycle of stimulus, queue the expectation, check at negedge.
    task automatic apply(input int sel, input vec_t v, input string nm);
        exp_t e;
        exp_t g;
        logic pc;
        logic [7:0] codes;
        logic [31:0] stc;
        logic [31:0] fle;
        logic to;
        @(posedge Clock);
        #1;
        set_in(v.mr, v.ert, v.rs, v.rt, v.ur, v.j, v.b, v.mb);
        e.sel = sel; e.pc = v.epc; e.codes = v.ecodes; e.nm = nm;
        sb.push_back(e);
        @(negedge Clock);
        g = sb.pop_front();
        get_out(g.sel, pc, codes, stc, fle, to);
        chk({g.nm, ".pc"}, {31'd0, pc}, {31'd0, g.pc});
        chk({g.nm, ".codes"}, {24'd0, codes}, {24'd0, g.codes});
    endtask

    function automatic vec_t mk(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                                input logic [4:0] rt, input logic ur, input logic j,
                                input logic b, input logic mb, input logic epc,
                                input logic [7:0] ec);
        vec_t v;
        v.mr = mr; v.ert = ert; v.rs = rs; v.rt = rt; v.ur = ur;
        v.j = j; v.b = b; v.mb = mb; v.epc = epc; v.ecodes = ec;
        return v;
    endfunction

    function automatic vec_t idle_exp(input logic epc, input logic [7:0] ec);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, epc, ec);
    endfunction

    task automatic do_reset();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pc;
        logic [7:0] codes;
        logic [31:0] stc;
        logic [31:0] fle;
        logic to;
        int exp_stalls;
        int exp_flushes;

        Reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        // mr ert rs rt ur j b mb -> pc codes
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, c_RUN);   // idle
        tbl[1]  = mk(1, 5, 5, 7, 0, 0, 0, 0, 0, c_STALL); // LU via Rs
        tbl[2]  = mk(0, 5, 5, 5, 1, 0, 0, 0, 1, c_RUN);   // match but no load
        tbl[3]  = mk(1, 6, 3, 6, 1, 0, 0, 0, 0, c_STALL); // LU via used Rt
        tbl[4]  = mk(1, 6, 3, 6, 0, 0, 0, 0, 1, c_RUN);   // Rt match, Rt unused
        tbl[5]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1, c_RUN);   // $0 load
        tbl[6]  = mk(0, 0, 1, 2, 1, 0, 1, 0, 1, c_BRCH);  // branch taken
        tbl[7]  = mk(0, 0, 1, 2, 1, 1, 0, 0, 1, c_JUMP);  // jump
        tbl[8]  = mk(1, 9, 9, 0, 0, 1, 0, 0, 0, c_STALL); // jump + LU: stall wins
        tbl[9]  = mk(1, 9, 9, 0, 0, 0, 1, 0, 1, c_BRCH);  // branch + LU: branch wins
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, c_HOLDC); // mem busy
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, c_HOLDC); // busy beats branch
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, c_RUN);   // back to RUN
        tbl[13] = mk(1, 4, 4, 0, 0, 0, 0, 1, 0, c_HOLDC); // busy beats LU

        // Reset mid LOAD_STALL (3-cycle stall instance)
        do_reset();
        apply(1, mk(1, 5, 5, 0, 0, 0, 0, 0, 0, c_STALL), "rst_lu");
        apply(1, idle_exp(0, c_STALL), "rst_stall2");
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(negedge Clock);
        get_out(1, pc, codes, stc, fle, to);
        chk("rst.pc", {31'd0, pc}, 32'd0);
        chk("rst.codes", {24'd0, codes}, {24'd0, c_RST});
        chk("rst.stall_cycles", stc, 32'd0);
        chk("rst.flush_events", fle, 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        get_out(1, pc, codes, stc, fle, to);
        chk("rst_rel.pc", {31'd0, pc}, 32'd1);
        chk("rst_rel.codes", {24'd0, codes}, {24'd0, c_RUN});

        // Table vectors on the default instance
        do_reset();
        exp_stalls = 0;
        exp_flushes = 0;
        for (int i = 0; i < 14; i++) begin
            apply(0, tbl[i], $sformatf("tbl%0d", i));
            if (tbl[i].epc == 1'b0) exp_stalls++;
            if (tbl[i].epc == 1'b1 && tbl[i].ecodes[7:6] == 2'd2) exp_flushes++;
        end
        apply(0, idle_exp(1, c_RUN), "tbl_end");
        get_out(0, pc, codes, stc, fle, to);
        chk("tbl.stall_cycles", stc, 32'(exp_stalls));
        chk("tbl.flush_events", fle, 32'(exp_flushes));

        // Default load-use: single bubble
        do_reset();
        apply(0, mk(1, 5, 5, 0, 0, 0, 0, 0, 0, c_STALL), "lu1");
        apply(0, idle_exp(1, c_RUN), "lu1_after");
        get_out(0, pc, codes, stc, fle, to);
        chk("lu1.stall_cycles", stc, 32'd1);

        // 3-cycle load stall with MemRead dropped after the first cycle
        do_reset();
        apply(1, mk(1, 5, 5, 0, 0, 0, 0, 0, 0, c_STALL), "lu3_c1");
        apply(1, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, c_STALL), "lu3_c2_jump");
        apply(1, idle_exp(0, c_STALL), "lu3_c3");
        apply(1, idle_exp(1, c_RUN), "lu3_done");
        get_out(1, pc, codes, stc, fle, to);
        chk("lu3.stall_cycles", stc, 32'd3);
        chk("lu3.flush_events", fle, 32'd0);

        // Branch aborts the stall in its second cycle
        do_reset();
        apply(1, mk(1, 5, 5, 0, 0, 0, 0, 0, 0, c_STALL), "brst_c1");
        apply(1, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, c_BRCH), "brst_br");
        apply(1, idle_exp(1, c_RUN), "brst_run");
        get_out(1, pc, codes, stc, fle, to);
        chk("brst.flush_events", fle, 32'd1);
        chk("brst.stall_cycles", stc, 32'd1);

        // Memory wait during a stall with 2 cycles left
        do_reset();
        apply(1, mk(1, 5, 5, 0, 0, 0, 0, 0, 0, c_STALL), "mw_c1");
        for (int i = 0; i < 4; i++)
            apply(1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, c_HOLDC), $sformatf("mw_busy%0d", i));
        apply(1, idle_exp(0, c_STALL), "mw_stall2");
        apply(1, idle_exp(0, c_STALL), "mw_stall3");
        apply(1, idle_exp(1, c_RUN), "mw_run");
        get_out(1, pc, codes, stc, fle, to);
        chk("mw.timeout", {31'd0, to}, 32'd0);
        chk("mw.stall_cycles", stc, 32'd7);

        // Timeout of 4 with 6 busy cycles: sticky until reset
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            apply(2, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, c_HOLDC), $sformatf("to_busy%0d", i));
            get_out(2, pc, codes, stc, fle, to);
            chk($sformatf("to_flag%0d", i), {31'd0, to}, (i >= 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            apply(2, idle_exp(1, c_RUN), $sformatf("to_idle%0d", i));
            get_out(2, pc, codes, stc, fle, to);
            chk($sformatf("to_sticky%0d", i), {31'd0, to}, 32'd1);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(negedge Clock);
        get_out(2, pc, codes, stc, fle, to);
        chk("to_reset", {31'd0, to}, 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        get_out(2, pc, codes, stc, fle, to);
        chk("to_after_reset", {31'd0, to}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
